// File: rtl/uart_rx_oversampled_pkg.sv
// Shared types for the oversampled UART receiver: RX state codes and the majority-vote helper.
// RX_ prefixed codes keep the receiver encodings apart from the transmitter's TX state names.
package uart_rx_oversampled_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// rx synchroniser, per-bit tick counter and 3-sample majority vote around the bit centre.
// The counter only runs while the receiver FSM holds active; it restarts from 0 on each frame.
module uart_rx_bit_sampler
    import uart_rx_oversampled_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic rx,
    input  logic active,
    output logic rx_s,
    output logic bit_strobe,
    output logic bit_val,
    output logic bit_end
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] TICK_LO   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] TICK_HI   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [1:0]             samp_q, samp_d;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
        tick_cnt_d = tick_cnt_q;
        samp_d     = samp_q;
        if (!active) begin
            tick_cnt_d = '0;
        end else if (en) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + CNT_W'(1);
            if (tick_cnt_q == TICK_LO)  samp_d[0] = rx_s;
            if (tick_cnt_q == TICK_MID) samp_d[1] = rx_s;
        end
    end

    // Third sample is the live rx_s, so the decision lands on the tick that takes it.
    assign bit_strobe = active && en && (tick_cnt_q == TICK_HI);
    assign bit_val    = maj3(samp_q[0], samp_q[1], rx_s);
    assign bit_end    = active && en && (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            tick_cnt_q <= '0;
            samp_q     <= 2'b11;
        end else begin
            sync_q     <= sync_d;
            tick_cnt_q <= tick_cnt_d;
            samp_q     <= samp_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) delivering bytes over valid/ready.
// Holds the frame FSM, shift register, output register, handshake and one-clk error pulses.
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    rx_state_e  state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       deliver;
    logic       active;
    logic       rx_s, bit_strobe, bit_val, bit_end;
`ifdef UART_RX_PARITY_EN
    logic       par_bad_q, par_bad_d;
    logic       parity_err_q, parity_err_d;
`endif

    assign active = (state_q == RX_START) || (state_q == RX_DATA) ||
                    (state_q == RX_PARITY) || (state_q == RX_STOP);

    uart_rx_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rx        (rx),
        .active    (active),
        .rx_s      (rx_s),
        .bit_strobe(bit_strobe),
        .bit_val   (bit_val),
        .bit_end   (bit_end)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                if (en && !rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (bit_strobe && bit_val) begin
                    state_d = RX_IDLE;
                end else if (bit_end) begin
                    state_d   = RX_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            RX_DATA: begin
                if (bit_strobe) shift_d = {bit_val, shift_q[7:1]};
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = RX_PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                // Even parity: data bits plus parity bit carry an even number of ones.
                if (bit_strobe) begin
                    par_bad_d    = (bit_val != ^shift_q);
                    parity_err_d = (bit_val != ^shift_q);
                end
                if (bit_end) state_d = RX_STOP;
            end
`endif
            RX_STOP: begin
                // Decide on the majority point and leave at once so the next start edge is caught.
                if (bit_strobe) begin
                    if (bit_val) begin
                        state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
                        deliver = !par_bad_q;
`else
                        deliver = 1'b1;
`endif
                    end else begin
                        state_d     = RX_BREAK;
                        frame_err_d = 1'b1;
                    end
                end
            end
            RX_BREAK: begin
                if (en && rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && ready) valid_d = 1'b0;
        // A consumer taking the old byte in the completion clk frees the slot for the new one.
        if (deliver) begin
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = active;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
